ltc2308_scan_seq: RTL and testbench

LTC2308_SCAN_SEQ -- requirements
Module: ltc2308_scan_seq

---
 rtl/ltc2308_pkg.sv | 62 ++++++
 rtl/ltc2308_period_timer.sv | 41 ++++
 rtl/ltc2308_scan_seq.sv | 216 +++++++++++++++++++++
 tb/tb_ltc2308_scan_seq.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ltc2308_pkg.sv
// ----------------------------------------------------------------------------
// ltc2308_pkg
//   Shared types and helpers for the LTC2308 scan sequencer.
//   - state_t    : sequencer FSM states
//   - CFG_*      : bit positions inside the 6-bit LTC2308 config word
//   - ch_sel_t   : result of a channel search (found flag + channel index)
//   - build_cfg  : config word for a single-ended channel
//   - find_chan  : lowest enabled channel at or above a starting index
// ----------------------------------------------------------------------------
package ltc2308_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    NEXT
  } state_t;

  localparam int CFG_W   = 6;
  localparam int CFG_SD  = 5;  // single-ended / differential
  localparam int CFG_OS  = 4;  // odd / sign
  localparam int CFG_S1  = 3;  // channel select bit 1
  localparam int CFG_S0  = 2;  // channel select bit 0
  localparam int CFG_UNI = 1;  // unipolar / bipolar
  localparam int CFG_SLP = 0;  // sleep

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } ch_sel_t;

  // LTC2308 single-ended mux map: O/S carries ch[0], while S1/S0 carry
  // ch[2]/ch[1] (CH2 -> 1001, CH4 -> 1010).
  function automatic logic [CFG_W-1:0] build_cfg(input logic [2:0] ch,
                                                 input logic       uni);
    logic [CFG_W-1:0] cfg;
    cfg          = '0;
    cfg[CFG_SD]  = 1'b1;
    cfg[CFG_OS]  = ch[0];
    cfg[CFG_S1]  = ch[2];
    cfg[CFG_S0]  = ch[1];
    cfg[CFG_UNI] = uni;
    cfg[CFG_SLP] = 1'b0;
    return cfg;
  endfunction

  // Searching downward lets the lowest qualifying index win.
  function automatic ch_sel_t find_chan(input logic [7:0] mask,
                                        input logic [3:0] from);
    ch_sel_t sel;
    sel = '0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= from)) begin
        sel.found = 1'b1;
        sel.idx   = 3'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/ltc2308_period_timer.sv
// ----------------------------------------------------------------------------
// ltc2308_period_timer
//   Free-running scan period timer. Counts while enabled and pulses expire
//   once every PERIOD cycles; load restarts the period, and the count is held
//   cleared while disabled so that enabling always yields a full period.
//
// Ports
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset (clears the count)
//   load   : restart the period (count returns to zero)
//   enable : run the timer
//   expire : one-cycle pulse on the last cycle of each period
// ----------------------------------------------------------------------------
module ltc2308_period_timer #(
  parameter int unsigned PERIOD = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] count;

  assign expire = enable && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load || !enable || expire) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ltc2308_scan_seq.sv
// ----------------------------------------------------------------------------
// ltc2308_scan_seq
//   Scan sequencer for an LTC2308 8-channel ADC behind a generic SPI transfer
//   engine. A scan walks the enabled channels in ascending order and issues
//   one transfer per conversion plus a trailing repeat, because the LTC2308
//   returns the result of the previous conversion on each transfer.
//
//   Optional feature macro: LTC2308_SCAN_AVG_EN
//     When defined, every channel is converted four times in a row and the
//     reported result is the truncated mean of the four samples.
//
// Ports
//   clk         : rising-edge clock
//   reset       : synchronous active-high reset; abandons any scan
//   start       : one-cycle single-scan request
//   continuous  : rescan every SCAN_PERIOD cycles while high
//   chan_en     : single-ended channel enable mask (latched at scan start)
//   xfer_req    : transfer request to the SPI engine
//   xfer_cfg    : config word for the requested transfer
//   xfer_ack    : engine accepted xfer_cfg
//   xfer_done   : one-cycle pulse, transfer complete
//   xfer_data   : conversion data, valid with xfer_done
//   res_valid   : one-cycle pulse, result on res_chan/res_data
//   res_chan    : channel index of the result
//   res_data    : conversion result
//   busy        : scan in progress
//   scan_done   : one-cycle pulse with the final result of a scan
//   overrun     : sticky, a trigger arrived while a scan was running
// ----------------------------------------------------------------------------
module ltc2308_scan_seq
  import ltc2308_pkg::*;
#(
  parameter int unsigned SCAN_PERIOD = 50000,
  parameter bit          UNIPOLAR    = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic [7:0]        chan_en,
  output logic              xfer_req,
  output logic [CFG_W-1:0]  xfer_cfg,
  input  logic              xfer_ack,
  input  logic              xfer_done,
  input  logic [11:0]       xfer_data,
  output logic              res_valid,
  output logic [2:0]        res_chan,
  output logic [11:0]       res_data,
  output logic              busy,
  output logic              scan_done,
  output logic              overrun
);

`ifdef LTC2308_SCAN_AVG_EN
  localparam logic [1:0] REP_LAST = 2'd3;
`else
  localparam logic [1:0] REP_LAST = 2'd0;
`endif

  state_t     state_q, state_d;

  logic [7:0] mask_q;       // channel mask captured at scan start
  logic [2:0] issue_ch_q;   // channel of the transfer being issued
  logic [1:0] issue_rep_q;  // conversion number of that channel
  logic [2:0] prev_ch_q;    // channel whose data the current transfer returns
  logic       first_q;      // current transfer is the first of the scan
  logic       final_q;      // current transfer is the trailing repeat

`ifdef LTC2308_SCAN_AVG_EN
  logic [1:0]  prev_rep_q;
  logic [13:0] acc_q;
  logic [13:0] sum;
`endif

  logic    expire;
  logic    trig;
  logic    scan_start;
  logic    done_acc;
  ch_sel_t first_sel;
  ch_sel_t next_sel;

  assign trig       = start || expire;
  assign first_sel  = find_chan(chan_en, 4'd0);
  assign next_sel   = find_chan(mask_q, {1'b0, issue_ch_q} + 4'd1);
  assign scan_start = (state_q == IDLE) && trig && first_sel.found;
  // xfer_done outside WAIT_DONE is deliberately dropped.
  assign done_acc   = (state_q == WAIT_DONE) && xfer_done;

  // Request is a pure state decode: high through ISSUE and WAIT_ACK, low on
  // the edge after xfer_ack is sampled in WAIT_ACK.
  assign xfer_req   = (state_q == ISSUE) || (state_q == WAIT_ACK);

`ifdef LTC2308_SCAN_AVG_EN
  // The first sample of a channel restarts the accumulator.
  assign sum = ((prev_rep_q == 2'd0) ? 14'd0 : acc_q) + 14'(xfer_data);
`endif

  ltc2308_period_timer #(
    .PERIOD (SCAN_PERIOD)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (scan_start),
    .enable (continuous),
    .expire (expire)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d gets its default before the case, so no path through this
  // block can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (scan_start) state_d = ISSUE;
      ISSUE:     state_d = WAIT_ACK;
      WAIT_ACK:  if (xfer_ack) state_d = WAIT_DONE;
      WAIT_DONE: if (xfer_done) state_d = NEXT;
      // busy has already dropped here when the trailing repeat returned.
      NEXT:      state_d = busy ? ISSUE : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q      <= '0;
      issue_ch_q  <= '0;
      issue_rep_q <= '0;
      prev_ch_q   <= '0;
      first_q     <= 1'b0;
      final_q     <= 1'b0;
      xfer_cfg    <= '0;
      res_valid   <= 1'b0;
      res_chan    <= '0;
      res_data    <= '0;
      busy        <= 1'b0;
      scan_done   <= 1'b0;
      overrun     <= 1'b0;
`ifdef LTC2308_SCAN_AVG_EN
      prev_rep_q  <= '0;
      acc_q       <= '0;
`endif
    end else begin
      res_valid <= 1'b0;
      scan_done <= 1'b0;

      // Any trigger outside IDLE is lost; only an accepted start clears it.
      if (trig && (state_q != IDLE)) begin
        overrun <= 1'b1;
      end else if (scan_start && start) begin
        overrun <= 1'b0;
      end

      if (scan_start) begin
        mask_q      <= chan_en;
        issue_ch_q  <= first_sel.idx;
        issue_rep_q <= '0;
        first_q     <= 1'b1;
        final_q     <= 1'b0;
        busy        <= 1'b1;
        xfer_cfg    <= build_cfg(first_sel.idx, UNIPOLAR);
      end

      if ((state_q == NEXT) && busy) begin
        xfer_cfg <= build_cfg(issue_ch_q, UNIPOLAR);
      end

      if (done_acc) begin
        first_q   <= 1'b0;
        prev_ch_q <= issue_ch_q;
`ifdef LTC2308_SCAN_AVG_EN
        prev_rep_q <= issue_rep_q;
        if (!first_q) begin
          acc_q <= sum;
          if (prev_rep_q == REP_LAST) begin
            res_valid <= 1'b1;
            res_chan  <= prev_ch_q;
            res_data  <= sum[13:2];
          end
        end
`else
        // Transfer 0 returns a stale conversion and is discarded.
        if (!first_q) begin
          res_valid <= 1'b1;
          res_chan  <= prev_ch_q;
          res_data  <= xfer_data;
        end
`endif
        if (final_q) begin
          busy      <= 1'b0;
          scan_done <= 1'b1;
        end else if (issue_rep_q != REP_LAST) begin
          issue_rep_q <= issue_rep_q + 2'd1;
        end else begin
          issue_rep_q <= '0;
          if (next_sel.found) begin
            issue_ch_q <= next_sel.idx;
          end else begin
            // Last channel done: repeat its config once to flush the pipeline.
            final_q <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ltc2308_scan_seq.sv
// ----------------------------------------------------------------------------
// tb_ltc2308_scan_seq
//   Directed bench for ltc2308_scan_seq with a behavioural SPI engine that
//   acks each request and returns data_base + k on transfer k of a scan.
// ----------------------------------------------------------------------------
module tb_ltc2308_scan_seq;

  localparam int PERIOD = 100;
  localparam int LIMIT  = 3000;
`ifdef LTC2308_SCAN_AVG_EN
  localparam int REPS    = 4;
  localparam int RES_OFF = 2;   // (4*base + 16j + 10) >> 2 = base + 4j + 2
`else
  localparam int REPS    = 1;
  localparam int RES_OFF = 1;   // channel j's data arrives on transfer j+1
`endif

  // LTC2308 single-ended config words, UNI=1, SLP=0, from the datasheet map.
  localparam logic [5:0] CFG_TAB [8] = '{
    6'b100010, 6'b110010, 6'b100110, 6'b110110,
    6'b101010, 6'b111010, 6'b101110, 6'b111110
  };

  logic        clk = 1'b0;
  logic        reset, start, continuous;
  logic [7:0]  chan_en;
  logic        xfer_req;
  logic [5:0]  xfer_cfg;
  logic        xfer_ack, xfer_done;
  logic [11:0] xfer_data;
  logic        res_valid;
  logic [2:0]  res_chan;
  logic [11:0] res_data;
  logic        busy, scan_done, overrun;

  always #5 clk = ~clk;

  ltc2308_scan_seq #(
    .SCAN_PERIOD (PERIOD),
    .UNIPOLAR    (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .continuous (continuous),
    .chan_en    (chan_en),
    .xfer_req   (xfer_req),
    .xfer_cfg   (xfer_cfg),
    .xfer_ack   (xfer_ack),
    .xfer_done  (xfer_done),
    .xfer_data  (xfer_data),
    .res_valid  (res_valid),
    .res_chan   (res_chan),
    .res_data   (res_data),
    .busy       (busy),
    .scan_done  (scan_done),
    .overrun    (overrun)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural SPI engine ----------------
  int          ack_delay  = 2;
  int          done_delay = 3;
  bit          early_done = 1'b0;
  logic [11:0] data_base  = '0;
  int          k0         = 0;
  int          xfer_cnt   = 0;
  int          stable_err = 0;
  logic [5:0]  cfg_log [1024];

  initial begin
    xfer_ack  = 1'b0;
    xfer_done = 1'b0;
    xfer_data = '0;
    forever begin
      @(negedge clk);
      if (xfer_req) begin
        cfg_log[xfer_cnt % 1024] = xfer_cfg;
        if (early_done) begin
          // Spurious done while the sequencer is still waiting for ack.
          @(negedge clk);
          xfer_data = 12'hBAD;
          xfer_done = 1'b1;
          @(negedge clk);
          xfer_done = 1'b0;
        end else begin
          repeat (ack_delay - 1) @(negedge clk);
        end
        if ((xfer_cfg !== cfg_log[xfer_cnt % 1024]) || !xfer_req) stable_err++;
        xfer_ack = 1'b1;
        @(negedge clk);
        xfer_ack = 1'b0;
        repeat (done_delay) @(negedge clk);
        xfer_data = data_base + 12'(xfer_cnt - k0);
        xfer_done = 1'b1;
        xfer_cnt++;
        @(negedge clk);
        xfer_done = 1'b0;
      end
    end
  end

  // ---------------- output monitor ----------------
  int          res_cnt  = 0;
  int          sd_cnt   = 0;
  int          req_cyc  = 0;
  int          busy_cyc = 0;
  logic [2:0]  log_chan [256];
  logic [11:0] log_data [256];
  logic        log_sd   [256];
  logic        log_busy [256];

  always @(negedge clk) begin
    if (res_valid) begin
      log_chan[res_cnt % 256] <= res_chan;
      log_data[res_cnt % 256] <= res_data;
      log_sd[res_cnt % 256]   <= scan_done;
      log_busy[res_cnt % 256] <= busy;
      res_cnt <= res_cnt + 1;
    end
    if (scan_done) sd_cnt   <= sd_cnt + 1;
    if (xfer_req)  req_cyc  <= req_cyc + 1;
    if (busy)      busy_cyc <= busy_cyc + 1;
  end

  // ---------------- helpers ----------------
  typedef struct {
    logic [7:0]  mask;
    int          n_ch;
    logic [31:0] chans;  // nibble i = i-th enabled channel, ascending
    logic [11:0] base;
  } vec_t;

  vec_t vecs [5];
  int   snap_x, snap_r;

  task automatic wait_sd(input int s0, input string name);
    int cyc = 0;
    while ((sd_cnt == s0) && (cyc < LIMIT)) begin
      @(negedge clk);
      cyc++;
    end
    check(name, 32'(cyc < LIMIT), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_scan(input logic [7:0] mask, input logic [11:0] base);
    int s0;
    data_base = base;
    k0        = xfer_cnt;
    snap_x    = xfer_cnt;
    snap_r    = res_cnt;
    s0        = sd_cnt;
    @(negedge clk);
    chan_en = mask;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    chan_en = ~mask;   // must not affect the running scan
    wait_sd(s0, "scan_timeout");
  endtask

  task automatic verify(input vec_t t);
    int n, nx, idx, e;
    n  = t.n_ch;
    nx = REPS * n + 1;
    check("xfer_count", 32'(xfer_cnt - snap_x), 32'(nx));
    for (int k = 0; k < nx; k++) begin
      idx = (k < REPS * n) ? (k / REPS) : (n - 1);
      check("xfer_cfg", 32'(cfg_log[(snap_x + k) % 1024]),
            32'(CFG_TAB[t.chans[4*idx +: 3]]));
    end
    check("res_count", 32'(res_cnt - snap_r), 32'(n));
    for (int j = 0; j < n; j++) begin
      e = (snap_r + j) % 256;
      check("res_chan", 32'(log_chan[e]), 32'(t.chans[4*j +: 3]));
      check("res_data", 32'(log_data[e]), 32'(t.base) + 32'(REPS * j + RES_OFF));
      check("scan_done_align", 32'(log_sd[e]), 32'(j == n - 1));
      if (j == n - 1) check("busy_low_at_done", 32'(log_busy[e]), 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_xfer_req"},  32'(xfer_req),  32'd0);
    check({tag, "_xfer_cfg"},  32'(xfer_cfg),  32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_chan"},  32'(res_chan),  32'd0);
    check({tag, "_res_data"},  32'(res_data),  32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_scan_done"}, 32'(scan_done), 32'd0);
    check({tag, "_overrun"},   32'(overrun),   32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int   s0, r0, b0, q0, x0, cyc;
    vec_t tmp;

    vecs[0] = '{8'h05, 2, 32'h0000_0020, 12'h100};
    vecs[1] = '{8'h80, 1, 32'h0000_0007, 12'h300};
    vecs[2] = '{8'hFF, 8, 32'h7654_3210, 12'h040};
    vecs[3] = '{8'h5A, 4, 32'h0000_6431, 12'h7F0};
    vecs[4] = '{8'h01, 1, 32'h0000_0000, 12'd9};

    reset      = 1'b1;
    start      = 1'b0;
    continuous = 1'b0;
    chan_en    = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Table-driven single scans.
    for (int v = 0; v < 5; v++) begin
      do_scan(vecs[v].mask, vecs[v].base);
      verify(vecs[v]);
      check("overrun_clear_scan", 32'(overrun), 32'd0);
    end

    // xfer_done during WAIT_ACK must be ignored.
    early_done = 1'b1;
    tmp        = vecs[0];
    tmp.base   = 12'h200;
    do_scan(tmp.mask, tmp.base);
    verify(tmp);
    early_done = 1'b0;

    // start while busy: dropped, sets overrun.
    data_base = 12'h000;
    k0        = xfer_cnt;
    snap_x    = xfer_cnt;
    s0        = sd_cnt;
    @(negedge clk);
    chan_en = 8'h05;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    repeat (4) @(negedge clk);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wait_sd(s0, "busy_start_timeout");
    check("overrun_busy_start", 32'(overrun), 32'd1);
    check("xfer_count_busy_start", 32'(xfer_cnt - snap_x), 32'(REPS * 2 + 1));
    do_scan(8'h05, 12'h000);
    check("overrun_cleared_by_start", 32'(overrun), 32'd0);

    // start with an empty mask does nothing.
    q0 = req_cyc;
    b0 = busy_cyc;
    s0 = sd_cnt;
    @(negedge clk);
    chan_en = 8'h00;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    repeat (20) @(negedge clk);
    check("zero_mask_req", 32'(req_cyc - q0), 32'd0);
    check("zero_mask_busy", 32'(busy_cyc - b0), 32'd0);
    check("zero_mask_done", 32'(sd_cnt - s0), 32'd0);

    // Reset in WAIT_DONE of transfer 1 abandons the scan.
    done_delay = 15;
    data_base  = 12'h500;
    k0         = xfer_cnt;
    snap_x     = xfer_cnt;
    @(negedge clk);
    chan_en = 8'h05;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    cyc = 0;
    while (!(xfer_req && (xfer_cnt - snap_x == 1)) && (cyc < 200)) begin
      @(negedge clk);
      cyc++;
    end
    while (xfer_req && (cyc < 250)) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_wait_done", 32'(cyc < 250), 32'd1);
    r0 = res_cnt;
    s0 = sd_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("rst_mid");
    q0 = req_cyc;
    repeat (40) @(negedge clk);
    check("rst_mid_no_result", 32'(res_cnt - r0), 32'd0);
    check("rst_mid_no_done", 32'(sd_cnt - s0), 32'd0);
    check("rst_mid_no_req", 32'(req_cyc - q0), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);

    // Continuous mode with scans longer than the period.
    done_delay = 40;
    data_base  = 12'h000;
    k0         = xfer_cnt;
    r0         = res_cnt;
    s0         = sd_cnt;
    @(negedge clk);
    chan_en    = 8'h05;
    continuous = 1'b1;
    cyc = 0;
    while ((sd_cnt - s0 < 3) && (cyc < LIMIT)) begin
      @(negedge clk);
      cyc++;
    end
    check("cont_three_scans", 32'(cyc < LIMIT), 32'd1);
    check("cont_overrun", 32'(overrun), 32'd1);
    check("cont_results", 32'(res_cnt - r0), 32'(2 * (sd_cnt - s0)));
    cyc = 0;
    while (!busy && (cyc < 400)) begin
      @(negedge clk);
      cyc++;
    end
    check("cont_next_scan", 32'(cyc < 400), 32'd1);
    continuous = 1'b0;
    s0 = sd_cnt;
    wait_sd(s0, "cont_scan_completes");
    x0 = xfer_cnt;
    repeat (400) @(negedge clk);
    check("cont_stopped_xfers", 32'(xfer_cnt - x0), 32'd0);
    check("cont_stopped_busy", 32'(busy), 32'd0);
    check("cont_overrun_sticky", 32'(overrun), 32'd1);
    s0 = sd_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("overrun_clear_idle_start", 32'(overrun), 32'd0);
    wait_sd(s0, "final_scan_timeout");
    done_delay = 3;

    check("cfg_stable_until_ack", 32'(stable_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule
